// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: consumes W0..W63 one word per accepted handshake,
// runs the rounds, folds the working variables into the chaining hash H0..H7.
module sha256_round_engine #(
  parameter int ROUNDS = 64
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         start_v_i,
  input  logic         first_block_i,
  output logic         ready_o,
  input  logic [31:0]  wt_i,
  input  logic         wt_v_i,
  output logic         wt_yumi_o,
  output logic [255:0] digest_o,
  output logic         digest_v_o,
  output logic [1:0]   state_o
);

  // Handshakes: start is taken when start_v_i & ready_o; a schedule word is taken
  // when wt_v_i & wt_yumi_o, and wt_yumi_o never depends on anything but wt_v_i and state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  t_q;
  logic [31:0] h_q   [0:7];
  logic [31:0] var_q [0:7];
  logic        digest_v_q;

  logic        start_acc;
  logic        round_en;
  logic [31:0] t1, t2, ch, maj;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    wt_yumi_o = 1'b0;
    start_acc = 1'b0;
    round_en  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_v_i) begin
          start_acc = 1'b1;
          state_d   = ROUND;
        end
      end
      ROUND: begin
        if (wt_v_i) begin
          wt_yumi_o = 1'b1;
          round_en  = 1'b1;
          if (t_q == LAST_T) state_d = FINAL;
        end
      end
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // var_q[0..7] hold a..h
  always_comb begin
    ch  = (var_q[4] & var_q[5]) ^ (~var_q[4] & var_q[6]);
    maj = (var_q[0] & var_q[1]) ^ (var_q[0] & var_q[2]) ^ (var_q[1] & var_q[2]);
    t1  = var_q[7] + big_sigma1(var_q[4]) + ch + K[t_q] + wt_i;
    t2  = big_sigma0(var_q[0]) + maj;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      t_q        <= '0;
      digest_v_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]   <= '0;
        var_q[i] <= '0;
      end
    end else begin
      if (start_acc) begin
        t_q        <= '0;
        digest_v_q <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (first_block_i) begin
            h_q[i]   <= IV[i];
            var_q[i] <= IV[i];
          end else begin
            var_q[i] <= h_q[i];
          end
        end
      end
      if (round_en) begin
        t_q      <= t_q + 6'd1;
        var_q[0] <= t1 + t2;
        var_q[1] <= var_q[0];
        var_q[2] <= var_q[1];
        var_q[3] <= var_q[2];
        var_q[4] <= var_q[3] + t1;
        var_q[5] <= var_q[4];
        var_q[6] <= var_q[5];
        var_q[7] <= var_q[6];
      end
      if (state_q == FINAL) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + var_q[i];
      end
      // digest_v stays up through IDLE until the next accepted start
      if (state_q == DONE) digest_v_q <= 1'b1;
    end
  end

  assign digest_o   = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  assign digest_v_o = digest_v_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests, latency,
// handshake counts, stalls, ignored starts and mid-block reset.
module tb_sha256_round_engine;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         start_v_i;
  logic         first_block_i;
  logic         ready_o;
  logic [31:0]  wt_i;
  logic         wt_v_i;
  logic         wt_yumi_o;
  logic [255:0] digest_o;
  logic         digest_v_o;
  logic [1:0]   state_o;

  sha256_round_engine #(.ROUNDS(64)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .start_v_i     (start_v_i),
    .first_block_i (first_block_i),
    .ready_o       (ready_o),
    .wt_i          (wt_i),
    .wt_v_i        (wt_v_i),
    .wt_yumi_o     (wt_yumi_o),
    .digest_o      (digest_o),
    .digest_v_o    (digest_v_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic [255:0] exp;
    logic         chk;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] w_arr [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference message schedule standing in for the upstream scheduler
  task automatic load_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w_arr[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w_arr[i-15], 7) ^ rotr(w_arr[i-15], 18) ^ (w_arr[i-15] >> 3);
      s1 = rotr(w_arr[i-2], 17) ^ rotr(w_arr[i-2], 19) ^ (w_arr[i-2] >> 10);
      w_arr[i] = s1 + w_arr[i-7] + s0 + w_arr[i-16];
    end
  endtask

  // Called at posedge+1 with the engine idle. cyc is the cycle in which
  // digest_v_o was first seen high, counted from the start cycle (0).
  task automatic run_block(input logic [511:0] blk, input logic first, input bit rnd,
                           input int pulse_a, input int pulse_b, input int rst_at,
                           output int cyc, output int yumis, output int stalls);
    int k;
    load_sched(blk);
    k = 0; yumis = 0; stalls = 0; cyc = 0;
    check("ready_before_start", {255'd0, ready_o}, 256'd1);
    start_v_i     = 1'b1;
    first_block_i = first;
    @(posedge clk_i); #1;
    start_v_i = 1'b0;
    cyc = 1;
    check("digest_v_falls_on_start", {255'd0, digest_v_o}, 256'd0);
    while (!digest_v_o && cyc < 2000) begin
      wt_v_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wt_i   = (k < 64) ? w_arr[k] : 32'hdead_beef;
      if (cyc == pulse_a || cyc == pulse_b) begin
        start_v_i     = 1'b1;
        first_block_i = ~first;
      end else begin
        start_v_i = 1'b0;
      end
      if (cyc == rst_at) begin
        reset_n_i = 1'b0;
        #1;
        check("rst_digest", digest_o, 256'd0);
        check("rst_digest_v", {255'd0, digest_v_o}, 256'd0);
        check("rst_yumi", {255'd0, wt_yumi_o}, 256'd0);
        check("rst_ready", {255'd0, ready_o}, 256'd1);
        wt_v_i = 1'b0;
        start_v_i = 1'b0;
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        #1;
        check("ready_after_release", {255'd0, ready_o}, 256'd1);
        @(posedge clk_i); #1;
        return;
      end
      if (!wt_v_i && k < 64) stalls++;
      #1;
      if (wt_yumi_o) begin
        yumis++;
        if (k < 64) k++;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    start_v_i = 1'b0;
    wt_v_i    = 1'b0;
    if (cyc >= 2000) check("digest_v_timeout", 256'd0, 256'd1);
  endtask

  int cyc, yumis, stalls;

  initial begin
    vecs[0] = '{blk: {32'h61626380, {14{32'h0}}, 32'h00000018}, first: 1'b1,
                exp: ABC_DIG, chk: 1'b1};
    vecs[1] = '{blk: {32'h80000000, {15{32'h0}}}, first: 1'b1,
                exp: 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855,
                chk: 1'b1};
    vecs[2] = '{blk: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
                first: 1'b1, exp: 256'd0, chk: 1'b0};
    vecs[3] = '{blk: {{15{32'h0}}, 32'h000001c0}, first: 1'b0,
                exp: 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1,
                chk: 1'b1};

    // clock/reset
    reset_n_i = 1'b0; start_v_i = 1'b0; first_block_i = 1'b0;
    wt_v_i = 1'b0; wt_i = '0;
    #13;
    check("reset_ready", {255'd0, ready_o}, 256'd1);
    check("reset_digest", digest_o, 256'd0);
    check("reset_digest_v", {255'd0, digest_v_o}, 256'd0);
    wt_v_i = 1'b1;
    #1;
    check("reset_yumi", {255'd0, wt_yumi_o}, 256'd0);
    wt_v_i = 1'b0;
    #4;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // known-answer blocks, including a two-block chain
    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].blk, vecs[i].first, 1'b0, -1, -1, -1, cyc, yumis, stalls);
      check($sformatf("vec%0d_latency", i), 256'(cyc), 256'd67);
      check($sformatf("vec%0d_yumis", i), 256'(yumis), 256'd64);
      if (vecs[i].chk) check($sformatf("vec%0d_digest", i), digest_o, vecs[i].exp);
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_digest_v_hold", i), {255'd0, digest_v_o}, 256'd1);
    end

    // random stalls on the schedule stream
    run_block(vecs[0].blk, 1'b1, 1'b1, -1, -1, -1, cyc, yumis, stalls);
    check("stall_latency", 256'(cyc), 256'(67 + stalls));
    check("stall_yumis", 256'(yumis), 256'd64);
    check("stall_digest", digest_o, ABC_DIG);

    // starts during round 10 and during FINAL are ignored
    run_block(vecs[0].blk, 1'b1, 1'b0, 11, 65, -1, cyc, yumis, stalls);
    check("ignore_start_latency", 256'(cyc), 256'd67);
    check("ignore_start_digest", digest_o, ABC_DIG);
    check("ignore_start_ready", {255'd0, ready_o}, 256'd1);

    // reset mid-block, then a clean rerun
    run_block(vecs[1].blk, 1'b1, 1'b0, -1, -1, 31, cyc, yumis, stalls);
    check("post_reset_digest_v", {255'd0, digest_v_o}, 256'd0);
    run_block(vecs[0].blk, 1'b1, 1'b0, -1, -1, -1, cyc, yumis, stalls);
    check("rerun_latency", 256'(cyc), 256'd67);
    check("rerun_digest", digest_o, ABC_DIG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Compression stage directly downstream of the message scheduler. It consumes the 64 schedule words W0..W63 for one 512-bit block, one word per cycle, through a valid/yumi handshake.
- Runs the 64 SHA-256 compression rounds and adds the working variables back into the chaining hash H0..H7.
- Presents the 256-bit digest to the padding/host controller. The chaining state is held internally, so multi-block messages chain without host involvement.

Parameters:
- ROUNDS, 64, compression rounds per block; fixed at 64 for SHA-256, exposed for reduced-round bench runs only.

Ports:
- clk_i  in  1  single clock
- reset_n_i  in  1  asynchronous active-low reset
- start_v_i  in  1  begin compressing a new block; accepted only when ready_o=1
- first_block_i  in  1  sampled with an accepted start; 1 loads FIPS 180-4 IV into H, 0 chains from current H
- ready_o  out  1  engine idle, start accepted this cycle if start_v_i=1
- wt_i  in  32  schedule word W_t from the message scheduler
- wt_v_i  in  1  wt_i valid
- wt_yumi_o  out  1  wt_i consumed this cycle (=wt_v_i & state==ROUND)
- digest_o  out  256  {H0..H7}, H0 in [255:224]
- digest_v_o  out  1  digest_o valid for the most recently completed block

Behaviour:
- Reset (async assert, sync release): state=IDLE, H0..H7=0, a..h=0, round counter t=0, ready_o=1, wt_yumi_o=0, digest_v_o=0, digest_o=0.
- K[0..63] is an internal constant ROM indexed by t.
- States:
  - IDLE: ready_o=1. On start_v_i:
    - If first_block_i=1: H is loaded with IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, and a..h load the IV.
    - Else: a..h load the current H.
    - In both cases t=0, digest_v_o clears, and the next state is ROUND.
  - ROUND: ready_o=0.
    - When wt_v_i=1, one round executes: T1=h+Σ1(e)+Ch(e,f,g)+K[t]+wt_i; T2=Σ0(a)+Maj(a,b,c); then h..a shift with e=d+T1 and a=T1+T2, and t increments.
    - When wt_v_i=0, the engine stalls with no state change and wt_yumi_o=0.
    - After the round with t=ROUNDS-1, the next state is FINAL.
  - FINAL (1 cycle): Hi=Hi+{a..h}i, then the next state is DONE.
  - DONE (1 cycle): digest_v_o=1, next state IDLE.
- Σ0 = rotr2^rotr13^rotr22; Σ1 = rotr6^rotr11^rotr25. All adds are mod 2^32, with carries discarded.
- digest_v_o stays high and digest_o stays stable until the next accepted start. It does not reassert on chained blocks until that block's DONE.
- Latency: start accepted in cycle 0 → first round can execute in cycle 1 → digest_v_o rises in cycle ROUNDS+3 with no stalls (cycle 67 for ROUNDS=64). Each stall cycle adds 1.
- start_v_i while not IDLE is ignored. No error is flagged, and first_block_i is not sampled.
- wt_v_i outside ROUND is ignored, and wt_yumi_o=0.
- Start on the same cycle as DONE is not possible because ready_o=0 in DONE. The earliest next start is in the cycle after DONE.
- Reset mid-block: all state clears immediately. The partial block and chaining value are lost. The host restarts with first_block_i=1.
- Chained start (first_block_i=0) immediately after reset chains from H=0. This is legal but meaningless; the host is responsible for avoiding it.

Test Plan:
1. Reset, then start first_block_i=1 with W for "abc" (W0=61626380, W1..W14=0, W15=00000018, W16..63 from reference model), wt_v_i held 1 → digest_v_o in cycle 67, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message (W0=80000000, W1..W15=0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first_block_i=1, block 2 with first_block_i=0 → final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. digest_v_o must fall on the second start.
4. Repeat case 1 with wt_v_i driven by a random 50% pattern → same digest. Cycle count equals 67 plus the number of stall cycles, and wt_yumi_o pulses exactly 64 times.
5. Pulse start_v_i at round 10 and at FINAL → ignored, digest unchanged. Then assert reset_n_i=0 at round 30 → all outputs 0 asynchronously, ready_o=1 after release, and a rerun of case 1 passes.
